// File: rtl/ext_int_filtr.sv
// External interrupt filter: synchronizes a raw pin, debounces it with a
// four-state FSM, and issues one-cycle interrupt pulses on the selected edge.
// An 8-bit saturating counter tracks issued pulses, with a sticky overflow flag.
module ext_int_filtr #(
   parameter int unsigned DB_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ext_in,
   input  logic [1:0] tryb,
   input  logic       kasuj,
   output logic       int_pulse,
   output logic       poziom,
   output logic [7:0] licznik,
   output logic       nadmiar
);

   typedef enum logic [1:0] {
      StabLow,
      SprHigh,
      StabHigh,
      SprLow
   } state_e;

   // Once cnt reaches this value, the next agreeing sample completes the run.
   localparam logic [7:0] DbLast = 8'(DB_CYCLES - 1);

   logic       sync1_q;
   logic       s;
   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       flip;
   logic       rise;
   logic       pulse_d;

   // Two-flop synchronizer; only sync1_q ever samples the raw pin.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         s       <= 1'b0;
      end else begin
         sync1_q <= ext_in;
         s       <= sync1_q;
      end
   end

   // Debounce next-state logic; flip marks the edge on which poziom toggles.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      flip    = 1'b0;
      unique case (state_q)
         StabLow: begin
            if (s) begin
               if (DB_CYCLES == 1) begin
                  state_d = StabHigh;
                  cnt_d   = 8'd0;
                  flip    = 1'b1;
               end else begin
                  state_d = SprHigh;
                  cnt_d   = 8'd1;
               end
            end else begin
               cnt_d = 8'd0;
            end
         end
         SprHigh: begin
            if (!s) begin
               state_d = StabLow;
               cnt_d   = 8'd0;
            end else if (cnt_q == DbLast) begin
               state_d = StabHigh;
               cnt_d   = 8'd0;
               flip    = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StabHigh: begin
            if (!s) begin
               if (DB_CYCLES == 1) begin
                  state_d = StabLow;
                  cnt_d   = 8'd0;
                  flip    = 1'b1;
               end else begin
                  state_d = SprLow;
                  cnt_d   = 8'd1;
               end
            end else begin
               cnt_d = 8'd0;
            end
         end
         SprLow: begin
            if (s) begin
               state_d = StabHigh;
               cnt_d   = 8'd0;
            end else if (cnt_q == DbLast) begin
               state_d = StabLow;
               cnt_d   = 8'd0;
               flip    = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = StabLow;
            cnt_d   = 8'd0;
         end
      endcase
   end

   // Edge select is sampled only at the flip edge, so tryb changes alone never pulse.
   always_comb begin
      rise    = (state_d == StabHigh);
      pulse_d = 1'b0;
      if (flip) begin
         unique case (tryb)
            2'b00:   pulse_d = rise;
            2'b01:   pulse_d = !rise;
            2'b10:   pulse_d = 1'b1;
            default: pulse_d = 1'b0;
         endcase
      end
   end

   // FSM state, debounce counter and registered level/pulse outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StabLow;
         cnt_q     <= 8'd0;
         poziom    <= 1'b0;
         int_pulse <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         poziom    <= poziom ^ flip;
         int_pulse <= pulse_d;
      end
   end

   // Saturating event counter; a clear that coincides with a pulse counts that pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         licznik <= 8'd0;
         nadmiar <= 1'b0;
      end else if (kasuj) begin
         licznik <= pulse_d ? 8'd1 : 8'd0;
         nadmiar <= 1'b0;
      end else if (pulse_d) begin
         if (licznik == 8'hFF) begin
            nadmiar <= 1'b1;
         end else begin
            licznik <= licznik + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_ext_int_filtr.sv
// Bench for ext_int_filtr: a run-length reference model pushes expected outputs
// each clock edge; a negedge sampler pops and compares. Directed checks cover
// latency, bounce rejection, edge modes, saturation and asynchronous reset.
module tb_ext_int_filtr;

   localparam int unsigned DB = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       ext_in;
   logic [1:0] tryb;
   logic       kasuj;
   logic       int_pulse;
   logic       poziom;
   logic [7:0] licznik;
   logic       nadmiar;

   int n_err = 0;
   int n_chk = 0;
   int pulse_seen = 0;
   int p0;

   typedef struct {
      logic       pulse;
      logic       lvl;
      logic [7:0] cnt;
      logic       ovf;
   } exp_t;

   exp_t sb_q[$];

   ext_int_filtr #(.DB_CYCLES(DB)) dut (
      .clk       (clk),
      .rst       (rst),
      .ext_in    (ext_in),
      .tryb      (tryb),
      .kasuj     (kasuj),
      .int_pulse (int_pulse),
      .poziom    (poziom),
      .licznik   (licznik),
      .nadmiar   (nadmiar)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: counts consecutive synchronized samples that disagree with the level.
   logic m_sync1, m_s, m_level, m_ovf;
   logic [7:0] m_cnt;
   int   m_run;
   always @(posedge clk or posedge rst) begin
      exp_t e;
      logic pulse_now;
      if (rst) begin
         m_sync1 = 0; m_s = 0; m_level = 0; m_run = 0; m_cnt = 0; m_ovf = 0;
         sb_q.delete();
         e.pulse = 0; e.lvl = 0; e.cnt = 0; e.ovf = 0;
         sb_q.push_back(e);
      end else begin
         pulse_now = 0;
         if (m_s != m_level) m_run++;
         else m_run = 0;
         if (m_run == int'(DB)) begin
            m_level = ~m_level;
            m_run   = 0;
            pulse_now = (tryb == 2'd2) || (tryb == 2'd0 && m_level) || (tryb == 2'd1 && !m_level);
         end
         if (kasuj) begin
            m_cnt = pulse_now ? 8'd1 : 8'd0;
            m_ovf = 0;
         end else if (pulse_now) begin
            if (m_cnt == 8'd255) m_ovf = 1;
            else m_cnt = m_cnt + 8'd1;
         end
         m_s     = m_sync1;
         m_sync1 = ext_in;
         e.pulse = pulse_now; e.lvl = m_level; e.cnt = m_cnt; e.ovf = m_ovf;
         sb_q.push_back(e);
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (int_pulse === 1'b1) pulse_seen++;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk("sb_pulse", int'(int_pulse), int'(e.pulse));
         chk("sb_poziom", int'(poziom), int'(e.lvl));
         chk("sb_licznik", int'(licznik), int'(e.cnt));
         chk("sb_nadmiar", int'(nadmiar), int'(e.ovf));
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic rise_fall();
      ext_in = 1'b1;
      repeat (7) tick();
      ext_in = 1'b0;
      repeat (7) tick();
   endtask

   task automatic mode_cycle(input logic [1:0] mode, input int exp_pulses);
      tryb = mode;
      tick();
      p0 = pulse_seen;
      ext_in = 1'b1;
      repeat (8) tick();
      chk("mode_hi_lvl", int'(poziom), 1);
      ext_in = 1'b0;
      repeat (8) tick();
      chk("mode_lo_lvl", int'(poziom), 0);
      chk("mode_pulses", pulse_seen - p0, exp_pulses);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout");
      n_err++;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      rst = 1'b1; ext_in = 1'b0; tryb = 2'b00; kasuj = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_poziom", int'(poziom), 0);
      chk("rst_pulse", int'(int_pulse), 0);
      chk("rst_licznik", int'(licznik), 0);
      chk("rst_nadmiar", int'(nadmiar), 0);
      repeat (3) tick();

      // Rise latency: first capture at edge 0, flip at edge DB+1.
      ext_in = 1'b1;
      repeat (DB + 1) tick();
      chk("rise_early", int'(poziom), 0);
      tick();
      chk("rise_lvl", int'(poziom), 1);
      chk("rise_pulse", int'(int_pulse), 1);
      tick();
      chk("rise_one", int'(int_pulse), 0);
      chk("rise_cnt", int'(licznik), 1);
      ext_in = 1'b0;
      repeat (8) tick();
      chk("fall_lvl", int'(poziom), 0);
      chk("fall_cnt", int'(licznik), 1);

      // Short high burst is rejected.
      p0 = pulse_seen;
      ext_in = 1'b1;
      repeat (DB - 1) tick();
      ext_in = 1'b0;
      repeat (8) tick();
      chk("bounce_lvl", int'(poziom), 0);
      chk("bounce_pulses", pulse_seen - p0, 0);

      // Glitch low while stable high is rejected.
      ext_in = 1'b1;
      repeat (8) tick();
      ext_in = 1'b0;
      repeat (2) tick();
      ext_in = 1'b1;
      repeat (8) tick();
      chk("glitch_lvl", int'(poziom), 1);
      chk("glitch_cnt", int'(licznik), 2);
      ext_in = 1'b0;
      repeat (8) tick();

      mode_cycle(2'b01, 1);
      mode_cycle(2'b10, 2);
      mode_cycle(2'b11, 0);
      mode_cycle(2'b00, 1);

      // Saturation and overflow.
      tryb = 2'b00;
      kasuj = 1'b1;
      tick();
      kasuj = 1'b0;
      chk("clr_cnt", int'(licznik), 0);
      for (int i = 0; i < 255; i++) rise_fall();
      chk("sat255_cnt", int'(licznik), 255);
      chk("sat255_ovf", int'(nadmiar), 0);
      rise_fall();
      chk("sat256_cnt", int'(licznik), 255);
      chk("sat256_ovf", int'(nadmiar), 1);

      // Clear coinciding with a pulse keeps that pulse.
      ext_in = 1'b1;
      repeat (DB + 1) tick();
      kasuj = 1'b1;
      tick();
      kasuj = 1'b0;
      chk("kp_pulse", int'(int_pulse), 1);
      chk("kp_cnt", int'(licznik), 1);
      chk("kp_ovf", int'(nadmiar), 0);
      ext_in = 1'b0;
      repeat (7) tick();
      rise_fall();
      chk("pre_clr_cnt", int'(licznik), 2);
      kasuj = 1'b1;
      tick();
      kasuj = 1'b0;
      chk("clr2_cnt", int'(licznik), 0);
      rise_fall();

      // Asynchronous reset mid-debounce.
      ext_in = 1'b1;
      repeat (3) tick();
      #1 rst = 1'b1;
      #1;
      chk("arst_licznik", int'(licznik), 0);
      chk("arst_poziom", int'(poziom), 0);
      chk("arst_pulse", int'(int_pulse), 0);
      chk("arst_nadmiar", int'(nadmiar), 0);
      tick();
      tick();
      rst = 1'b0;
      p0 = pulse_seen;
      repeat (DB + 1) tick();
      chk("rel_early", int'(poziom), 0);
      chk("rel_nopulse", pulse_seen - p0, 0);
      tick();
      chk("rel_lvl", int'(poziom), 1);
      chk("rel_pulse", int'(int_pulse), 1);
      tick();
      chk("rel_cnt", int'(licznik), 1);

      repeat (3) tick();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
